// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, command-master state encoding,
// response payload type and the watchdog counter width helper.
package axi_lite_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } cmd_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [1:0]            resp;
        logic                  timeout;
    } rsp_t;

    // Counter must hold TIMEOUT_CYCLES; never narrower than one bit.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Transaction watchdog. Counts active cycles since i_clear; o_expired_c is high
// in every enabled cycle from the TIMEOUT_CYCLES-th onward. TIMEOUT_CYCLES = 0
// disables expiry.
// Ports: i_axi_clk/i_axi_rst (sync, active-high), i_clear, i_enable, o_expired_c.
module axi_lite_watchdog
    import axi_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic i_axi_clk,
    input  logic i_axi_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at LAST so a phase started after expiry still aborts unless it completes at once.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired_c = WD_ON && i_enable && (cnt_q == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command stream into
// AXI-Lite reads/writes and returns one response per command, with a watchdog
// abort (resp SLVERR, timeout flag) against a hung slave.
// Ports: command stream (i_cmd_*, o_cmd_ready), response stream (o_rsp_*,
// i_rsp_ready), AXI-Lite AW/W/B/AR/R channels. All outputs are flops.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [STRB_WIDTH-1:0] i_cmd_wstrb,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_rsp_timeout,
    output logic                  o_awvalid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    input  logic                  i_wready,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_arvalid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [1:0]            i_rresp,
    input  logic [DATA_WIDTH-1:0] i_rdata
);

    cmd_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    rsp_t                  rsp_q, rsp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  wd_clear_c, wd_enable_c, wd_expired_c;
    logic                  abort_c;

    axi_lite_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_axi_clk   (i_axi_clk),
        .i_axi_rst   (i_axi_rst),
        .i_clear     (wd_clear_c),
        .i_enable    (wd_enable_c),
        .o_expired_c (wd_expired_c)
    );

    // Next-state and next-output logic; handshakes are checked before expiry so they win ties.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wd_clear_c  = 1'b0;
        wd_enable_c = 1'b0;
        abort_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = i_cmd_addr;
                    wdata_d     = i_cmd_wdata;
                    wstrb_d     = i_cmd_wstrb;
                    wd_clear_c  = 1'b1;
                    if (i_cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                wd_enable_c = 1'b1;
                // AW and W retire independently; a dropped valid marks that channel done.
                awvalid_d = awvalid_q && !i_awready;
                wvalid_d  = wvalid_q && !i_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end else if (wd_expired_c) begin
                    abort_c = 1'b1;
                end
            end
            ST_WR_RESP: begin
                wd_enable_c = 1'b1;
                if (bready_q && i_bvalid) begin
                    state_d       = ST_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.resp    = i_bresp;
                    rsp_d.timeout = 1'b0;
                end else if (wd_expired_c) begin
                    abort_c = 1'b1;
                end else begin
                    bready_d = 1'b1;
                end
            end
            ST_RD_REQ: begin
                wd_enable_c = 1'b1;
                if (arvalid_q && i_arready) begin
                    state_d  = ST_RD_DATA;
                    rready_d = 1'b1;
                end else if (wd_expired_c) begin
                    abort_c = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_RD_DATA: begin
                wd_enable_c = 1'b1;
                if (rready_q && i_rvalid) begin
                    state_d       = ST_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = i_rdata;
                    rsp_d.resp    = i_rresp;
                    rsp_d.timeout = 1'b0;
                end else if (wd_expired_c) begin
                    abort_c = 1'b1;
                end else begin
                    rready_d = 1'b1;
                end
            end
            ST_RSP: begin
                rsp_valid_d = 1'b1;
                if (rsp_valid_q && i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog abort: drop every AXI valid/ready and report SLVERR with the timeout flag.
        if (abort_c) begin
            state_d       = ST_RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_d.rdata   = '0;
            rsp_d.resp    = AXI_RESP_SLVERR;
            rsp_d.timeout = 1'b1;
        end
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_q.rdata;
    assign o_rsp_resp    = rsp_q.resp;
    assign o_rsp_timeout = rsp_q.timeout;
    assign o_awvalid     = awvalid_q;
    assign o_awaddr      = addr_q;
    assign o_wvalid      = wvalid_q;
    assign o_wdata       = wdata_q;
    assign o_wstrb       = wstrb_q;
    assign o_bready      = bready_q;
    assign o_arvalid     = arvalid_q;
    assign o_araddr      = addr_q;
    assign o_rready      = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a delay-programmable AXI-Lite slave plus a
// per-transaction timing/response model derived from handshake cycle arithmetic.
module tb_axi_lite_cmd_master;
    import axi_lite_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs for the next transaction.
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_axi_clk     (clk),
        .i_axi_rst     (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_write   (cmd_write),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wdata   (cmd_wdata),
        .i_cmd_wstrb   (cmd_wstrb),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_resp    (rsp_resp),
        .o_rsp_timeout (rsp_timeout),
        .o_awvalid     (awvalid),
        .o_awaddr      (awaddr),
        .i_awready     (awready),
        .o_wvalid      (wvalid),
        .o_wdata       (wdata),
        .o_wstrb       (wstrb),
        .i_wready      (wready),
        .i_bvalid      (bvalid),
        .o_bready      (bready),
        .i_bresp       (bresp),
        .o_arvalid     (arvalid),
        .o_araddr      (araddr),
        .i_arready     (arready),
        .i_rvalid      (rvalid),
        .o_rready      (rready),
        .i_rresp       (rresp),
        .i_rdata       (rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Called once per negedge: ready/valid rises after the master's signal has been seen for N cycles.
    task automatic slave_step();
        if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
        else begin wready = 1'b0; w_cnt = 0; end
        if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin arready = 1'b0; ar_cnt = 0; end
        if (bready) begin bvalid = (b_cnt >= b_dly); bresp = s_bresp; b_cnt++; end
        else begin bvalid = 1'b0; bresp = 2'b00; b_cnt = 0; end
        if (rready) begin rvalid = (r_cnt >= r_dly); rresp = s_rresp; rdata = s_rdata; r_cnt++; end
        else begin rvalid = 1'b0; rresp = 2'b00; rdata = '0; r_cnt = 0; end
    endtask

    // One command end to end. Cycle 1 is the first cycle after the accepting edge.
    // Model: a phase whose handshake lands at cycle h succeeds iff h <= max(TMO, phase start);
    // otherwise it aborts at cycle max(TMO, phase start) and the response shows the cycle after.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int hold, input string tag);
        int ha, hw, hb, har, hr, d, abort_at, ok_at;
        int exp_aw, exp_w, exp_ar, exp_cyc;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_tmo;
        int cyc, n, aw_hi, w_hi, ar_hi, rsp_first, rsp_n;
        bit bad_addr, bad_ready, bad_stable, hs_pending, finished;
        logic [31:0] c_rdata;
        logic [1:0]  c_resp;
        logic        c_tmo;

        abort_at = 0; ok_at = 0; exp_aw = 0; exp_w = 0; exp_ar = 0;
        if (wr) begin
            ha = 1 + aw_dly; hw = 1 + w_dly;
            exp_aw = imin(ha, TMO); exp_w = imin(hw, TMO);
            d = imax(ha, hw);
            if (d > TMO) abort_at = TMO;
            else begin
                hb = d + 1 + b_dly;
                if (hb > imax(TMO, d + 1)) abort_at = imax(TMO, d + 1);
                else ok_at = hb;
            end
        end else begin
            har = 1 + ar_dly;
            exp_ar = imin(har, TMO);
            if (har > TMO) abort_at = TMO;
            else begin
                hr = har + 1 + r_dly;
                if (hr > imax(TMO, har + 1)) abort_at = imax(TMO, har + 1);
                else ok_at = hr;
            end
        end
        if (abort_at != 0) begin
            exp_cyc = abort_at + 1; exp_rdata = '0; exp_resp = AXI_RESP_SLVERR; exp_tmo = 1'b1;
        end else begin
            exp_cyc = ok_at + 1; exp_tmo = 1'b0;
            exp_rdata = wr ? 32'h0 : s_rdata;
            exp_resp  = wr ? s_bresp : s_rresp;
        end

        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            check($sformatf("%s.accept", tag), 64'(cmd_ready), 64'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;

        cyc = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; rsp_first = 0; rsp_n = 0;
        bad_addr = 0; bad_ready = 0; bad_stable = 0; hs_pending = 0; finished = 0;
        c_rdata = '0; c_resp = '0; c_tmo = 1'b0;
        while (!finished && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) cmd_valid = 1'b0;
            if (hs_pending) begin
                rsp_ready = 1'b0;
                check($sformatf("%s.idle_after", tag), {62'd0, cmd_ready, rsp_valid}, 64'b10);
                finished = 1;
            end else begin
                if (cmd_ready) bad_ready = 1;
                if (awvalid) begin aw_hi++; if (awaddr !== addr) bad_addr = 1; end
                if (wvalid) begin w_hi++; if (wdata !== wd || wstrb !== ws) bad_addr = 1; end
                if (arvalid) begin ar_hi++; if (araddr !== addr) bad_addr = 1; end
                if (rsp_valid) begin
                    if (rsp_first == 0) begin
                        rsp_first = cyc; c_rdata = rsp_rdata; c_resp = rsp_resp; c_tmo = rsp_timeout;
                    end else if (rsp_rdata !== c_rdata || rsp_resp !== c_resp || rsp_timeout !== c_tmo) begin
                        bad_stable = 1;
                    end
                    rsp_ready = (rsp_n >= hold);
                    rsp_n++;
                    hs_pending = rsp_ready;
                end
                slave_step();
            end
        end
        if (!finished) check($sformatf("%s.done_in_budget", tag), 64'd0, 64'd1);
        check($sformatf("%s.rsp_cycle", tag), 64'(rsp_first), 64'(exp_cyc));
        check($sformatf("%s.rdata", tag), 64'(c_rdata), 64'(exp_rdata));
        check($sformatf("%s.resp", tag), 64'(c_resp), 64'(exp_resp));
        check($sformatf("%s.timeout", tag), 64'(c_tmo), 64'(exp_tmo));
        check($sformatf("%s.aw_cycles", tag), 64'(aw_hi), 64'(exp_aw));
        check($sformatf("%s.w_cycles", tag), 64'(w_hi), 64'(exp_w));
        check($sformatf("%s.ar_cycles", tag), 64'(ar_hi), 64'(exp_ar));
        check($sformatf("%s.payload_ok", tag), 64'(bad_addr), 64'd0);
        check($sformatf("%s.cmd_ready_low", tag), 64'(bad_ready), 64'd0);
        check($sformatf("%s.rsp_stable", tag), 64'(bad_stable), 64'd0);
    endtask

    task automatic set_slave(input int a, input int w, input int b, input int ar, input int r,
                             input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
        s_bresp = br; s_rresp = rr; s_rdata = rd;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);

        repeat (3) @(negedge clk);
        check("reset.ctrl", {56'd0, cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout}, 64'd0);
        check("reset.data", {rsp_rdata, awaddr}, 64'd0);
        check("reset.wdata", {wdata, 26'd0, rsp_resp, wstrb}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset.cmd_ready_rise", 64'(cmd_ready), 64'd1);

        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, "wr_basic");
        set_slave(0, 0, 0, 3, 0, 2'b00, 2'b00, 32'h1234_5678);
        run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, "rd_ar_wait");
        set_slave(2, 0, 0, 0, 0, 2'b11, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 4'h5, 0, "wr_w_first");
        set_slave(0, 2, 1, 0, 0, 2'b01, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0104, 32'h0BAD_F00D, 4'h3, 0, "wr_aw_first");
        set_slave(0, 0, 0, 50, 0, 2'b00, 2'b00, 32'hFFFF_FFFF);
        run_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, "rd_hung");
        set_slave(0, 0, 0, 0, 1, 2'b00, 2'b01, 32'hCAFE_0001);
        run_txn(1'b0, 32'h0000_000C, 32'h0, 4'h0, 0, "rd_after_tmo");
        set_slave(0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h5555_AAAA);
        run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 5, "rd_rsp_hold");
        set_slave(0, 0, 0, 0, 6, 2'b00, 2'b11, 32'h7777_0000);
        run_txn(1'b0, 32'h0000_0024, 32'h0, 4'h0, 0, "rd_r_at_expiry");
        set_slave(0, 0, 0, 7, 0, 2'b00, 2'b00, 32'h1111_2222);
        run_txn(1'b0, 32'h0000_0028, 32'h0, 4'h0, 0, "rd_ar_at_expiry");
        set_slave(0, 0, 0, 7, 1, 2'b00, 2'b00, 32'h3333_4444);
        run_txn(1'b0, 32'h0000_002C, 32'h0, 4'h0, 0, "rd_r_late");
        set_slave(7, 3, 0, 0, 0, 2'b10, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0030, 32'h1357_9BDF, 4'hC, 0, "wr_b_at_expiry");
        set_slave(8, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0034, 32'h2468_ACE0, 4'hF, 2, "wr_aw_hung");

        for (int i = 0; i < 40; i++) begin
            set_slave(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                      2'($urandom), 2'($urandom), $urandom);
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                    $sformatf("rand%0d", i));
        end

        // Reset while waiting in WR_RESP: nothing may be reported afterwards.
        set_slave(0, 0, 10, 0, 0, 2'b00, 2'b00, 32'h0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h99; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        slave_step();
        @(negedge clk);
        check("rstmid.in_wr_resp", {62'd0, bready, awvalid}, 64'b10);
        slave_step();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.cleared", {57'd0, cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        slave_step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.ready_back", {62'd0, cmd_ready, rsp_valid}, 64'b10);
        slave_step();
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0044, 32'h0000_00AA, 4'h1, 0, "wr_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Upstream driver for the AXI-Lite slave port of the NES core (axi_nes).
- Converts a simple single-beat command/response stream (from a host bridge, CPU shim or bench sequencer) into compliant AXI4-Lite read/write transactions.
- One outstanding transaction at a time, with a watchdog timeout against a hung slave.

Parameters:
- ADDR_WIDTH, 32, width of command address and AWADDR/ARADDR.
- TIMEOUT_CYCLES, 1024, cycles allowed from issue to B/R completion; 0 disables the watchdog.

Ports:
- i_axi_clk  in  1  clock, all logic on rising edge.
- i_axi_rst  in  1  reset, synchronous, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid & ready.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_WIDTH  byte address.
- i_cmd_wdata  in  32  write data.
- i_cmd_wstrb  in  4  write strobes.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed.
- o_rsp_rdata  out  32  read data; 0 for writes and timeouts.
- o_rsp_resp  out  2  AXI response code.
- o_rsp_timeout  out  1  transaction aborted by watchdog.
- o_awvalid  out  1  AXI write address valid.
- o_awaddr  out  ADDR_WIDTH  AXI write address.
- i_awready  in  1  AXI write address ready.
- o_wvalid  out  1  AXI write data valid.
- o_wdata  out  32  AXI write data.
- o_wstrb  out  4  AXI write strobes.
- i_wready  in  1  AXI write data ready.
- i_bvalid  in  1  AXI write response valid.
- o_bready  out  1  AXI write response ready.
- i_bresp  in  2  AXI write response code.
- o_arvalid  out  1  AXI read address valid.
- o_araddr  out  ADDR_WIDTH  AXI read address.
- i_arready  in  1  AXI read address ready.
- i_rvalid  in  1  AXI read data valid.
- o_rready  out  1  AXI read data ready.
- i_rresp  in  2  AXI read response code.
- i_rdata  in  32  AXI read data.

Behaviour:
- Reset (i_axi_rst = 1 at an edge):
  - state IDLE; all valid/ready outputs 0; o_rsp_rdata/o_rsp_resp/o_rsp_timeout 0; address/data regs 0.
  - o_cmd_ready rises the first cycle after reset deasserts.
- Reset mid-transaction: abandon immediately, same values as reset, no response emitted.
- All outputs are registered; no combinational path from any input to any output.
- States and transitions:
  - IDLE: o_cmd_ready = 1. On accept, latch all command fields.
    - write -> WR_REQ; read -> RD_REQ.
  - WR_REQ: o_awvalid and o_wvalid both high from the cycle after accept.
    - Each deasserts on the edge after its own handshake; AW and W may complete in either order or the same cycle.
    - Both done -> WR_RESP.
  - WR_RESP: o_bready = 1; on i_bvalid capture i_bresp, rdata = 0 -> RSP.
  - RD_REQ: o_arvalid = 1 until i_arready -> RD_DATA.
  - RD_DATA: o_rready = 1; on i_rvalid capture i_rdata and i_rresp -> RSP.
  - RSP: o_rsp_valid = 1, outputs held stable until i_rsp_ready -> IDLE.
    - o_cmd_ready = 0 in RSP: no back-to-back overlap.
- Latency (slave always ready, zero-wait responder):
  - write: accept at cycle 0, AW/W handshake cycle 1, B cycle 2, o_rsp_valid cycle 3.
  - read: accept cycle 0, AR cycle 1, R cycle 2, o_rsp_valid cycle 3.
- Valids never deassert before their handshake except on watchdog abort or reset.
- Watchdog:
  - Counter clears on command accept and increments each cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - Reaching TIMEOUT_CYCLES forces all AXI valids/readies to 0 -> RSP with resp = 2'b10, timeout = 1, rdata = 0.
  - A handshake completing in the same cycle as expiry wins; timeout is not flagged.
- Response codes pass through unmodified, including 2'b01/2'b11. o_rsp_timeout = 0 for all non-aborted transactions.

Decomposition:
- Shared package axi_lite_pkg: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants; state encoding for this block; timeout counter width = clog2(TIMEOUT_CYCLES+1).
- One sub-module: axi_lite_watchdog (clear, enable, expired). Everything else stays in a single FSM.

Test Plan:
- Write 0x0000_0010, data 0xDEAD_BEEF, strb 0xF, zero-wait slave -> AW/W seen cycle 1 with those values, o_rsp_valid cycle 3, resp 0, rdata 0, timeout 0.
- Read 0x0000_0004, slave returns 0x1234_5678/OKAY after 3-cycle ARREADY delay -> o_arvalid held 4 cycles with stable address, rsp rdata 0x1234_5678, resp 0.
- Write, slave gives WREADY 2 cycles before AWREADY, then BRESP 2'b11 -> each valid drops independently after its handshake, response resp 2'b11.
- TIMEOUT_CYCLES = 8, read with slave never asserting ARREADY -> o_arvalid drops after 8 cycles, rsp resp 2'b10, timeout 1, rdata 0; next command then accepted normally.
- Hold i_rsp_ready low 5 cycles after read completion -> rsp fields stable, o_cmd_ready 0 throughout, IDLE one cycle after ready.
- Assert i_axi_rst while in WR_RESP -> next edge all valids/readies 0, no response, o_cmd_ready 1 the cycle after reset release.
